// File: rtl/uba_dma_xfer.sv
// uba_dma_xfer: KS10-side DMA engine for the UBA (read, write, read-merge-write).
// Define UBA_DMA_RPW_LOCK_EN to drive busLOCKO across RPW read-merge-write.
module uba_dma_xfer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devREQI,
  input  logic        devWRITE,
  input  logic        devBYTE,
  input  logic [35:0] devADDRI,
  input  logic [35:0] devDATAI,
  input  logic [3:0]  pageFLAGS,
  input  logic        pageFAIL,
  output logic        devACKO,
  output logic        devNXMO,
  output logic [35:0] devDATAO,
  output logic        busREQO,
  output logic        busWRO,
  output logic        busLOCKO,
  output logic [35:0] busADDRO,
  output logic [35:0] busDATAO,
  input  logic        busACKI,
  input  logic [35:0] busDATAI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_MERGE,
    S_WR,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [35:0] E16_MASK = 36'o600000600000;

`ifdef UBA_DMA_RPW_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_byte;
  logic        r_rpw;
  logic        r_e16;
  logic        r_ftm;
  logic        r_pfail;
  logic        r_lock;
  logic [35:0] r_addr;
  logic [35:0] r_data;
  logic [35:0] r_word;
  logic [7:0]  r_cnt;

  logic        w_rd;
  logic        w_wr;
  logic        w_mrg;
  logic        w_tmo;
  logic        w_hsel;
  logic [17:0] w_src;
  logic [17:0] w_old;
  logic [17:0] w_new;
  logic [35:0] w_merged;
  logic        w_unused;

  assign w_rd  = (r_state == S_RD);
  assign w_wr  = (r_state == S_WR);
  assign w_mrg = (r_state == S_MERGE);
  assign w_tmo = (r_cnt == TO_LAST);

  // Address bit 34 (vector bit 1) picks the half; 0 selects LH.
  assign w_hsel = r_addr[1];

  always_comb begin
    w_src = w_hsel ? r_data[17:0] : r_data[35:18];
    w_old = w_hsel ? r_word[17:0] : r_word[35:18];
    w_new = w_old;
    if (r_byte) begin
      if (r_addr[0]) begin
        w_new[15:8] = w_src[7:0];
      end else begin
        w_new[7:0] = w_src[7:0];
      end
    end else begin
      w_new = w_src;
    end
    if (r_e16) begin
      w_new[17:16] = 2'b00;
    end
    w_merged = w_hsel ? {r_word[35:18], w_new}
                      : {w_new, r_word[17:0]};
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (devREQI) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_pfail) begin
          w_next = S_FAIL;
        end else if (r_write && r_ftm) begin
          w_next = S_WR;
        end else begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        if (busACKI) begin
          w_next = r_write ? S_MERGE : S_DONE;
        end else if (w_tmo) begin
          w_next = S_FAIL;
        end
      end
      S_MERGE: begin
        w_next = S_WR;
      end
      S_WR: begin
        if (busACKI) begin
          w_next = S_DONE;
        end else if (w_tmo) begin
          w_next = S_FAIL;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_FAIL: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_rpw   <= 1'b0;
      r_e16   <= 1'b0;
      r_ftm   <= 1'b0;
      r_pfail <= 1'b0;
      r_lock  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_lock <= 1'b0;
        if (devREQI) begin
          r_write <= devWRITE;
          r_byte  <= devBYTE;
          r_addr  <= devADDRI;
          r_data  <= devDATAI;
          r_rpw   <= pageFLAGS[0];
          r_e16   <= pageFLAGS[1];
          r_ftm   <= pageFLAGS[2];
          r_pfail <= pageFAIL;
        end
      end
      if (r_state == S_CHECK) begin
        if (r_write && r_ftm) begin
          r_word <= r_data;
        end
        r_lock <= LOCK_EN && r_write && !r_ftm
                  && r_rpw && !r_pfail;
      end
      if (w_rd && busACKI) begin
        r_word <= busDATAI;
      end
      if (w_mrg) begin
        r_word <= w_merged;
      end
      // Counts unanswered request cycles; idle states hold it at 0.
      if ((w_rd || w_wr) && !busACKI) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign devACKO  = (r_state == S_DONE);
  assign devNXMO  = (r_state == S_FAIL);
  assign devDATAO = (devACKO && !r_write)
                  ? (r_e16 ? (r_word & ~E16_MASK) : r_word)
                  : '0;
  assign busREQO  = w_rd | w_wr;
  assign busWRO   = w_wr;
  assign busADDRO = {r_addr[35:2], 2'b00};
  assign busDATAO = w_wr ? r_word : '0;

`ifdef UBA_DMA_RPW_LOCK_EN
  assign busLOCKO = r_lock & (w_rd | w_mrg | w_wr);
  assign w_unused = pageFLAGS[3];
`else
  assign busLOCKO = 1'b0;
  assign w_unused = ^{pageFLAGS[3], r_lock, r_rpw};
`endif

endmodule
